// File: rtl/ccu_pkg.sv
// ----------------------------------------------------------------------------
// ccu_pkg
// Shared types and helpers for the pipelined CCU add/sub/accumulate unit.
//   ccu_mode_e   : operation select (ADD, SUB, ACC, ACCSUB)
//   CCU_B_INIT   : LUT contents of the CCU_B carry-chain cell (sum = a^b^ci)
//   ccu_stages() : number of pipeline segments for a WIDTH/SEG pair
//   mode_is_sub(): operation inverts B and uses a borrow-style carry-in
//   mode_is_acc(): operation takes its A operand from the accumulator
// ----------------------------------------------------------------------------
package ccu_pkg;

    typedef enum logic [1:0] {
        CCU_ADD    = 2'd0,
        CCU_SUB    = 2'd1,
        CCU_ACC    = 2'd2,
        CCU_ACCSUB = 2'd3
    } ccu_mode_e;

    // LUT index is {ci, b, a, unused}; the table evaluates a ^ b ^ ci.
    localparam logic [15:0] CCU_B_INIT = 16'hc33c;

    function automatic int ccu_stages(input int width, input int seg);
        return (width + seg - 1) / seg;
    endfunction

    function automatic logic mode_is_sub(input ccu_mode_e m);
        return (m == CCU_SUB) || (m == CCU_ACCSUB);
    endfunction

    function automatic logic mode_is_acc(input ccu_mode_e m);
        return (m == CCU_ACC) || (m == CCU_ACCSUB);
    endfunction

endpackage

// File: rtl/ccu_seg.sv
// ----------------------------------------------------------------------------
// ccu_seg
// Purely combinational W-bit carry-chain segment. Consecutive bit pairs map
// onto one CCU_B cell: the sum comes from the cell LUT, the carry from the
// dedicated carry logic (majority of a, b', ci).
// Ports:
//   a_seg    in  W  operand A bits of this segment
//   b_seg    in  W  operand B bits of this segment
//   inv_b    in  1  invert B (subtract)
//   ci       in  1  carry into the segment LSB
//   s_seg    out W  segment sum
//   co       out 1  carry out of the segment MSB
//   c_msb_in out 1  carry into the segment MSB (for signed overflow)
// ----------------------------------------------------------------------------
module ccu_seg
    import ccu_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] a_seg,
    input  logic [W-1:0] b_seg,
    input  logic         inv_b,
    input  logic         ci,
    output logic [W-1:0] s_seg,
    output logic         co,
    output logic         c_msb_in
);

    logic       c;
    logic       b_eff;
    logic [3:0] lut_idx;

    always_comb begin
        // NOTE: every output and temporary gets a default before the loop so
        // no path leaves a value unassigned (which would infer a latch).
        c        = ci;
        b_eff    = 1'b0;
        lut_idx  = '0;
        s_seg    = '0;
        c_msb_in = 1'b0;
        for (int i = 0; i < W; i++) begin
            b_eff   = b_seg[i] ^ inv_b;
            if (i == W - 1) begin
                c_msb_in = c;
            end
            lut_idx  = {c, b_eff, a_seg[i], 1'b0};
            s_seg[i] = CCU_B_INIT[lut_idx];
            c        = (a_seg[i] & b_eff) | (a_seg[i] & c) | (b_eff & c);
        end
        co = c;
    end

endmodule

// File: rtl/ccu_pipe_addsub.sv
// ----------------------------------------------------------------------------
// ccu_pipe_addsub
// Pipelined add/sub/accumulate unit. WIDTH-bit operands are cut into SEG-bit
// segments; segment k is computed in stage k from the carry registered by
// stage k-1 of the same beat (skewed carry pipeline). Each stage register
// carries the finished low result bits forward and the not-yet-used upper
// operand bits, so all result bits leave the last stage aligned.
// A stall (out_valid & !out_ready) freezes every stage at once.
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   in_valid / in_ready  operand beat handshake
//   mode                 ccu_mode_e: ADD, SUB, ACC, ACCSUB
//   a, b, cin            operands and carry/borrow in
//   acc_clr              zero the accumulator with this beat
//   out_valid/out_ready  result handshake
//   sum, cout, ovf       result, carry out (NOT borrow for SUB), signed ovf
// ----------------------------------------------------------------------------
module ccu_pipe_addsub
    import ccu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SEG   = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = ccu_stages(WIDTH, SEG);
    localparam int TOP_W  = WIDTH - (STAGES - 1) * SEG;

    // Stage registers; index k holds the beat that finished segment k.
    logic             vld_q  [STAGES], vld_d  [STAGES];
    ccu_mode_e        mode_q [STAGES], mode_d [STAGES];
    logic             clr_q  [STAGES], clr_d  [STAGES];
    logic             cry_q  [STAGES], cry_d  [STAGES];
    logic [WIDTH-1:0] res_q  [STAGES], res_d  [STAGES];
    logic [WIDTH-1:0] a_q    [STAGES], a_d    [STAGES];
    logic [WIDTH-1:0] b_q    [STAGES], b_d    [STAGES];
    logic [SEG-1:0]   acc_q  [STAGES], acc_d  [STAGES];
    logic             ovf_q, ovf_d;

    // What each stage sees at its input: primary inputs for stage 0,
    // the previous stage register otherwise.
    logic             src_vld  [STAGES];
    ccu_mode_e        src_mode [STAGES];
    logic             src_clr  [STAGES];
    logic             src_ci   [STAGES];
    logic [WIDTH-1:0] src_res  [STAGES];
    logic [WIDTH-1:0] src_a    [STAGES];
    logic [WIDTH-1:0] src_b    [STAGES];

    logic [SEG-1:0]   seg_a    [STAGES];
    logic [SEG-1:0]   seg_b    [STAGES];
    logic             seg_inv  [STAGES];
    logic [SEG-1:0]   seg_s    [STAGES];
    logic             seg_co   [STAGES];
    logic             seg_cmsb [STAGES];

    logic             en;

    assign out_valid = vld_q[STAGES-1];
    assign sum       = res_q[STAGES-1];
    assign cout      = cry_q[STAGES-1];
    assign ovf       = ovf_q;

    // Global enable: the only back-pressure point is the pipeline tail.
    assign en       = !(out_valid && !out_ready);
    assign in_ready = en;

    always_comb begin
        src_vld[0]  = in_valid;
        src_mode[0] = ccu_mode_e'(mode);
        src_clr[0]  = acc_clr;
        // Subtract is a + ~b + !borrow_in.
        src_ci[0]   = cin ^ mode_is_sub(ccu_mode_e'(mode));
        src_res[0]  = '0;
        src_a[0]    = a;
        src_b[0]    = b;
        for (int k = 1; k < STAGES; k++) begin
            src_vld[k]  = vld_q[k-1];
            src_mode[k] = mode_q[k-1];
            src_clr[k]  = clr_q[k-1];
            src_ci[k]   = cry_q[k-1];
            src_res[k]  = res_q[k-1];
            src_a[k]    = a_q[k-1];
            src_b[k]    = b_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            // Accumulate modes read acc segment k, already holding the
            // previous ACC beat's result; a clear makes the beat read zero.
            if (mode_is_acc(src_mode[k])) begin
                seg_a[k] = src_clr[k] ? '0 : acc_q[k];
            end else begin
                seg_a[k] = SEG'(src_a[k] >> (k * SEG));
            end
            seg_b[k]   = SEG'(src_b[k] >> (k * SEG));
            seg_inv[k] = mode_is_sub(src_mode[k]);
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_seg
        localparam int W = (k == STAGES - 1) ? TOP_W : SEG;
        logic [W-1:0] s_loc;

        ccu_seg #(.W(W)) u_seg (
            .a_seg    (seg_a[k][W-1:0]),
            .b_seg    (seg_b[k][W-1:0]),
            .inv_b    (seg_inv[k]),
            .ci       (src_ci[k]),
            .s_seg    (s_loc),
            .co       (seg_co[k]),
            .c_msb_in (seg_cmsb[k])
        );

        // Narrow top segment is zero-padded so upper bits never leak.
        assign seg_s[k] = SEG'(s_loc);
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            vld_d[k]  = src_vld[k];
            mode_d[k] = src_mode[k];
            clr_d[k]  = src_clr[k];
            cry_d[k]  = seg_co[k];
            a_d[k]    = src_a[k];
            b_d[k]    = src_b[k];
            // Bits of segment k and above are still zero in src_res.
            res_d[k]  = src_res[k] | (WIDTH'(seg_s[k]) << (k * SEG));
            acc_d[k]  = acc_q[k];
            if (src_vld[k]) begin
                if (mode_is_acc(src_mode[k])) begin
                    acc_d[k] = seg_s[k];
                end else if (src_clr[k]) begin
                    acc_d[k] = '0;
                end
            end
        end
        ovf_d = seg_cmsb[STAGES-1] ^ seg_co[STAGES-1];
    end

    // NOTE: the accumulator segments are ordinary flops, not a RAM, so they
    // are cleared by reset along with the rest of the pipeline state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k]  <= 1'b0;
                mode_q[k] <= CCU_ADD;
                clr_q[k]  <= 1'b0;
                cry_q[k]  <= 1'b0;
                res_q[k]  <= '0;
                a_q[k]    <= '0;
                b_q[k]    <= '0;
                acc_q[k]  <= '0;
            end
            ovf_q <= 1'b0;
        end else if (en) begin
            // NOTE: non-blocking so every stage samples the pre-edge value
            // of the stage before it.
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k]  <= vld_d[k];
                mode_q[k] <= mode_d[k];
                clr_q[k]  <= clr_d[k];
                cry_q[k]  <= cry_d[k];
                res_q[k]  <= res_d[k];
                a_q[k]    <= a_d[k];
                b_q[k]    <= b_d[k];
                acc_q[k]  <= acc_d[k];
            end
            ovf_q <= ovf_d;
        end
    end

endmodule
